// File: rtl/force_reg_pkg.sv
// Shared types and helpers for the force register bank.
// Channel FSM states and hold-counter width.
package force_reg_pkg;

  typedef enum logic [1:0] {
    ST_NORMAL = 2'd0,
    ST_FORCED = 2'd1,
    ST_HOLD   = 2'd2
  } chan_state_e;

  function automatic int hold_cnt_w(input int rh);
    return (rh < 2) ? 1 : $clog2(rh + 1);
  endfunction

endpackage

// File: rtl/force_reg_channel.sv
// One force-able register channel: NORMAL/FORCED/HOLD FSM,
// release hold counter and data register. Optional FORCE_CNT_EN.
module force_reg_channel
  import force_reg_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int RELEASE_HOLD = 1
) (
  input  logic             CLOCK,
  input  logic             RST,
  input  logic             select,
  input  logic [WIDTH-1:0] force_value,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] state,
  output logic             forced
`ifdef FORCE_CNT_EN
  ,
  output logic             force_entry
`endif
);

  localparam int CW = hold_cnt_w(RELEASE_HOLD);
  localparam logic [CW-1:0] HOLD_INIT = CW'(RELEASE_HOLD);

  chan_state_e      cur;
  chan_state_e      nxt;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_n;
  logic [WIDTH-1:0] data_n;

  always_ff @(posedge CLOCK) begin
    if (RST) begin
      cur    <= ST_NORMAL;
      cnt    <= '0;
      state  <= '0;
      forced <= 1'b0;
    end else begin
      cur    <= nxt;
      cnt    <= cnt_n;
      state  <= data_n;
      forced <= (nxt != ST_NORMAL);
    end
  end

  always_comb begin
    nxt    = cur;
    cnt_n  = cnt;
    data_n = state;
    unique case (cur)
      ST_NORMAL: begin
        if (select) begin
          data_n = force_value;
          nxt    = ST_FORCED;
        end else if (load) begin
          data_n = data_in;
        end
      end
      ST_FORCED: begin
        if (select) begin
          data_n = force_value;
        end else if (RELEASE_HOLD == 0) begin
          nxt = ST_NORMAL;
        end else begin
          nxt   = ST_HOLD;
          cnt_n = HOLD_INIT;
        end
      end
      ST_HOLD: begin
        if (select) begin
          data_n = force_value;
          nxt    = ST_FORCED;
          cnt_n  = '0;
        end else begin
          // Leaving at 1 means LOAD opens RELEASE_HOLD+1 cycles after release.
          cnt_n = cnt - 1'b1;
          if (cnt <= CW'(1)) begin
            nxt   = ST_NORMAL;
            cnt_n = '0;
          end
        end
      end
      default: begin
        nxt   = ST_NORMAL;
        cnt_n = '0;
      end
    endcase
  end

`ifdef FORCE_CNT_EN
  assign force_entry = select && (cur != ST_FORCED);
`endif

endmodule

// File: rtl/force_reg_bank.sv
// Bank of independent force-able registers with packed I/O.
// Define FORCE_CNT_EN to add the saturating FORCE_CNT output.
module force_reg_bank
  import force_reg_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int CHANNELS     = 4,
  parameter int RELEASE_HOLD = 1
) (
  input  logic                      CLOCK,
  input  logic                      RST,
  input  logic [CHANNELS-1:0]       SELECT,
  input  logic [WIDTH-1:0]          FORCE_VALUE,
  input  logic [CHANNELS-1:0]       LOAD,
  input  logic [CHANNELS*WIDTH-1:0] DATA_IN,
  output logic [CHANNELS*WIDTH-1:0] STATE,
  output logic [CHANNELS-1:0]       FORCED
`ifdef FORCE_CNT_EN
  ,
  output logic [7:0]                FORCE_CNT
`endif
);

`ifdef FORCE_CNT_EN
  logic [CHANNELS-1:0] entry;
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    force_reg_channel #(
      .WIDTH       (WIDTH),
      .RELEASE_HOLD(RELEASE_HOLD)
    ) u_ch (
      .CLOCK      (CLOCK),
      .RST        (RST),
      .select     (SELECT[i]),
      .force_value(FORCE_VALUE),
      .load       (LOAD[i]),
      .data_in    (DATA_IN[i*WIDTH +: WIDTH]),
      .state      (STATE[i*WIDTH +: WIDTH]),
      .forced     (FORCED[i])
`ifdef FORCE_CNT_EN
      ,
      .force_entry(entry[i])
`endif
    );
  end

`ifdef FORCE_CNT_EN
  // Any number of channels entering in one cycle counts once.
  always_ff @(posedge CLOCK) begin
    if (RST) begin
      FORCE_CNT <= '0;
    end else if (|entry && FORCE_CNT != 8'hFF) begin
      FORCE_CNT <= FORCE_CNT + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_force_reg_bank.sv
// Self-checking bench for force_reg_bank (RELEASE_HOLD=3).
// FORCE_CNT checks are compiled in when FORCE_CNT_EN is defined.
module tb_force_reg_bank;

  localparam int W  = 4;
  localparam int CH = 4;
  localparam int RH = 3;

  logic          CLOCK = 1'b0;
  logic          RST;
  logic [CH-1:0] SELECT;
  logic [W-1:0]  FORCE_VALUE;
  logic [CH-1:0] LOAD;
  logic [15:0]   DATA_IN;
  logic [15:0]   STATE;
  logic [CH-1:0] FORCED;
`ifdef FORCE_CNT_EN
  logic [7:0]    FORCE_CNT;
`endif

  force_reg_bank #(
    .WIDTH       (W),
    .CHANNELS    (CH),
    .RELEASE_HOLD(RH)
  ) dut (
    .CLOCK      (CLOCK),
    .RST        (RST),
    .SELECT     (SELECT),
    .FORCE_VALUE(FORCE_VALUE),
    .LOAD       (LOAD),
    .DATA_IN    (DATA_IN),
    .STATE      (STATE),
    .FORCED     (FORCED)
`ifdef FORCE_CNT_EN
    ,
    .FORCE_CNT  (FORCE_CNT)
`endif
  );

  always #5 CLOCK = ~CLOCK;

  int tests = 0;
  int fails = 0;

  // Reference: a channel is "held" while SELECT was high last edge,
  // then LOAD stays blocked for RH further edges after release.
  int m_val[CH];
  bit m_sel[CH];
  int m_left[CH];
  int m_cnt;

  function automatic void model_edge();
    bit any;
    any = 1'b0;
    if (RST) begin
      for (int i = 0; i < CH; i++) begin
        m_val[i]  = 0;
        m_sel[i]  = 1'b0;
        m_left[i] = 0;
      end
      m_cnt = 0;
      return;
    end
    for (int i = 0; i < CH; i++) begin
      if (SELECT[i]) begin
        if (!m_sel[i]) any = 1'b1;
        m_val[i]  = int'(FORCE_VALUE);
        m_sel[i]  = 1'b1;
        m_left[i] = 0;
      end else if (m_sel[i]) begin
        m_sel[i]  = 1'b0;
        m_left[i] = RH;
      end else if (m_left[i] > 0) begin
        m_left[i] = m_left[i] - 1;
      end else if (LOAD[i]) begin
        m_val[i] = int'(DATA_IN[i*W +: W]);
      end
    end
    if (any && m_cnt < 255) m_cnt = m_cnt + 1;
  endfunction

  task automatic chk(input string tag);
    logic [15:0]   es;
    logic [CH-1:0] ef;
    for (int i = 0; i < CH; i++) begin
      es[i*W +: W] = m_val[i][W-1:0];
      ef[i]        = m_sel[i] || (m_left[i] > 0);
    end
    tests++;
    assert (STATE === es) else begin
      fails++;
      $error("FAIL %s state obs=%h exp=%h", tag, STATE, es);
    end
    tests++;
    assert (FORCED === ef) else begin
      fails++;
      $error("FAIL %s forced obs=%b exp=%b", tag, FORCED, ef);
    end
`ifdef FORCE_CNT_EN
    tests++;
    assert (FORCE_CNT === 8'(m_cnt)) else begin
      fails++;
      $error("FAIL %s cnt obs=%0d exp=%0d", tag, FORCE_CNT, m_cnt);
    end
`endif
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input string tag);
    @(posedge CLOCK);
    model_edge();
    #1;
    chk(tag);
  endtask

  initial begin
    RST = 1'b1; SELECT = '0; FORCE_VALUE = '0;
    LOAD = 4'hF; DATA_IN = 16'hFFFF;
    tick("reset");
    chk16("reset_state", STATE, 16'h0000);
    chk16("reset_forced", 16'(FORCED), 16'h0);

    RST = 1'b0; LOAD = 4'hF; DATA_IN = 16'hA5C3;
    tick("load_all");
    chk16("load_all_c", STATE, 16'hA5C3);

    SELECT = 4'b0010; FORCE_VALUE = 4'h9; DATA_IN = 16'h1234;
    tick("force_ch1");
    chk16("force_ch1_c", STATE, 16'h1294);
    chk16("force_ch1_f", 16'(FORCED), 16'h2);

    SELECT = '0; LOAD = 4'b0010; DATA_IN = 16'h0060;
    for (int k = 0; k < 4; k++) begin
      tick("hold");
      chk16("hold_c", 16'(STATE[7:4]), 16'h9);
    end
    chk16("hold_f_low", 16'(FORCED), 16'h0);
    tick("release_load");
    chk16("release_load_c", 16'(STATE[7:4]), 16'h6);

    SELECT = 4'b0010; FORCE_VALUE = 4'h9; LOAD = 4'b0010;
    tick("reforce");
    SELECT = '0;
    tick("hold2a");
    tick("hold2b");
    SELECT = 4'b0010; FORCE_VALUE = 4'h2;
    tick("hold_reforce");
    chk16("hold_reforce_c", 16'(STATE[7:4]), 16'h2);
    SELECT = '0;
    for (int k = 0; k < 4; k++) begin
      tick("hold3");
      chk16("hold3_c", 16'(STATE[7:4]), 16'h2);
    end
    tick("hold3_load");
    chk16("hold3_load_c", 16'(STATE[7:4]), 16'h6);

    LOAD = '0; SELECT = 4'b0101; FORCE_VALUE = 4'hE;
    tick("f02");
    SELECT = 4'b0001;
    tick("f0_h2");
    RST = 1'b1;
    tick("mid_rst");
    chk16("mid_rst_c", STATE, 16'h0000);
    RST = 1'b0; SELECT = '0; LOAD = 4'hF; DATA_IN = 16'h7777;
    tick("post_rst");
    chk16("post_rst_c", STATE, 16'h7777);

    for (int k = 0; k < 400; k++) begin
      RST         = ($urandom_range(0, 39) == 0);
      SELECT      = ($urandom_range(0, 2) == 0) ? 4'($urandom) : '0;
      LOAD        = 4'($urandom);
      DATA_IN     = 16'($urandom);
      FORCE_VALUE = 4'($urandom);
      tick("rand");
    end

`ifdef FORCE_CNT_EN
    RST = 1'b1;
    tick("cnt_rst");
    RST = 1'b0;
    for (int k = 0; k < 600; k++) begin
      SELECT = (k % 2 == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      FORCE_VALUE = 4'($urandom);
      tick("cnt_sat");
    end
    chk16("cnt_sat_c", 16'(FORCE_CNT), 16'd255);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
